// File: rtl/draw_sequencer.sv
// draw_sequencer: clears the screen, plots every live player head plus a timer bar each pass,
// then wipes the screen. Optional feature macro: DRAW_SEQ_WINNER_BANNER_EN (winner banner after wipe).
module draw_sequencer #(
  parameter int NUM_PLAYERS = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119,
  parameter int TIMER_ROW   = 119,
  parameter int PID_W       = 3
) (
  input  logic                               CLOCK_50,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               tick,
  input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0]   pos,
  input  logic [NUM_PLAYERS*3-1:0]           player_colours,
  input  logic [NUM_PLAYERS-1:0]             alive,
  input  logic [PID_W-1:0]                   winner,
  output logic [X_W-1:0]                     x,
  output logic [Y_W-1:0]                     y,
  output logic [2:0]                         colour,
  output logic                               plot,
  output logic                               running,
  output logic                               round_done,
  output logic [2:0]                         dbg_state,
  output logic [X_W-1:0]                     dbg_timer_x,
  output logic                               dbg_expired,
  output logic [PID_W-1:0]                   dbg_win_q
);

  localparam int PW     = X_W + Y_W;
  localparam int SLOT_W = $clog2(NUM_PLAYERS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_WIPE   = 3'd3;
`ifdef DRAW_SEQ_WINNER_BANNER_EN
  localparam logic [2:0] S_BANNER = 3'd4;
`endif
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [X_W-1:0]    X_LAST    = X_W'(X_MAX);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0]    BAR_ROW   = Y_W'(TIMER_ROW);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_PLAYERS);

  // start and tick are single-cycle strobes: each is acted on only in the cycle it is high,
  // and only in the states that listen to it; there is no back-pressure toward the sources.

  logic [2:0]        state, state_nx;
  logic [X_W-1:0]    cx;
  logic [Y_W-1:0]    cy;
  logic [SLOT_W-1:0] slot;
  logic [X_W-1:0]    timer_x;
  logic              expired;
  logic [PID_W-1:0]  win_q;

  logic              sweeping, sweep_last, slot_last, round_start;
  logic [X_W-1:0]    sel_x;
  logic [Y_W-1:0]    sel_y;
  logic [2:0]        sel_col;
  logic              sel_alive;

`ifdef DRAW_SEQ_WINNER_BANNER_EN
  localparam logic [X_W-1:0] BAN_X0 = X_W'(X_MAX / 2 - 8);
  localparam logic [Y_W-1:0] BAN_Y0 = Y_W'(Y_MAX / 2 - 4);
  logic [3:0] bx;
  logic [2:0] by;
  logic [2:0] win_col;
  logic       banner_last;

  // Out-of-range winner indices fall through to white.
  always_comb begin
    win_col = 3'b111;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      if (win_q == PID_W'(k)) win_col = player_colours[k*3 +: 3];
    end
  end

  assign banner_last = (bx == 4'd15) && (by == 3'd7);
`endif

  assign sweeping    = (state == S_CLEAR) || (state == S_WIPE);
  assign sweep_last  = (cx == X_LAST) && (cy == Y_LAST);
  assign slot_last   = (slot == SLOT_LAST);
  assign round_start = start && ((state == S_IDLE) || (state == S_DONE));

  assign dbg_state   = state;
  assign dbg_timer_x = timer_x;
  assign dbg_expired = expired;
  assign dbg_win_q   = win_q;

  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_col   = '0;
    sel_alive = 1'b0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      if (slot == SLOT_W'(k)) begin
        sel_x     = pos[k*PW+Y_W +: X_W];
        sel_y     = pos[k*PW +: Y_W];
        sel_col   = player_colours[k*3 +: 3];
        sel_alive = alive[k];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_CLEAR;
      S_CLEAR:  if (sweep_last) state_nx = S_RUN;
      S_RUN:    if (slot_last && expired) state_nx = S_WIPE;
`ifdef DRAW_SEQ_WINNER_BANNER_EN
      S_WIPE:   if (sweep_last) state_nx = S_BANNER;
      S_BANNER: if (banner_last) state_nx = S_DONE;
`else
      S_WIPE:   if (sweep_last) state_nx = S_DONE;
`endif
      S_DONE:   if (start) state_nx = S_CLEAR;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= S_IDLE;
      cx         <= '0;
      cy         <= '0;
      slot       <= '0;
      timer_x    <= '0;
      expired    <= 1'b0;
      win_q      <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= 3'b000;
      plot       <= 1'b0;
      running    <= 1'b0;
      round_done <= 1'b0;
`ifdef DRAW_SEQ_WINNER_BANNER_EN
      bx         <= '0;
      by         <= '0;
`endif
    end else begin
      state      <= state_nx;
      running    <= (state == S_RUN);
      round_done <= (state == S_DONE);

      // Sweep counters idle at zero so every sweep begins at (0,0).
      if (sweeping) begin
        if (cx == X_LAST) begin
          cx <= '0;
          cy <= (cy == Y_LAST) ? '0 : cy + Y_W'(1);
        end else begin
          cx <= cx + X_W'(1);
        end
      end else begin
        cx <= '0;
        cy <= '0;
      end

      if (state == S_RUN) slot <= slot_last ? '0 : slot + SLOT_W'(1);
      else                slot <= '0;

      if (round_start) begin
        timer_x <= '0;
        expired <= 1'b0;
      end else if ((state == S_RUN) && tick) begin
        if (timer_x == X_LAST) begin
          if (!expired) win_q <= winner;
          expired <= 1'b1;
        end else begin
          timer_x <= timer_x + X_W'(1);
        end
      end

`ifdef DRAW_SEQ_WINNER_BANNER_EN
      if (state == S_BANNER) begin
        bx <= bx + 4'd1;
        if (bx == 4'd15) by <= by + 3'd1;
      end else begin
        bx <= '0;
        by <= '0;
      end
`endif

      // Output registers follow the current state, hence one cycle behind it.
      case (state)
        S_CLEAR, S_WIPE: begin
          x      <= cx;
          y      <= cy;
          colour <= 3'b000;
          plot   <= 1'b1;
        end
        S_RUN: begin
          if (slot_last) begin
            x      <= timer_x;
            y      <= BAR_ROW;
            colour <= 3'b111;
            plot   <= 1'b1;
          end else begin
            x      <= sel_x;
            y      <= sel_y;
            colour <= sel_col;
            plot   <= sel_alive;
          end
        end
`ifdef DRAW_SEQ_WINNER_BANNER_EN
        S_BANNER: begin
          x      <= BAN_X0 + X_W'(bx);
          y      <= BAN_Y0 + Y_W'(by);
          colour <= win_col;
          plot   <= 1'b1;
        end
`endif
        default: plot <= 1'b0;
      endcase
    end
  end

endmodule
